// File: rtl/soc_ctrl_pkg.sv
// Shared types for the SoC controller clock/reset release sequencer.
package soc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } soc_ctrl_seq_state_e;

endpackage

// File: rtl/soc_ctrl_clk_rst_seq_gen_if.sv
// Per-domain clock/reset/enable bundle between the sequencer and the clock domains it gates.
interface soc_ctrl_clk_rst_seq_gen_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
);

    logic [NUM_CH-1:0]            clk_i;
    logic [NUM_CH-1:0]            arst_ni;
    logic [NUM_CH-1:0]            clk_en_i;
    logic [NUM_CH-1:0][CNT_W-1:0] delay_i;
    logic [NUM_CH-1:0]            clk_o;
    logic [NUM_CH-1:0]            arst_no;
    logic [NUM_CH-1:0]            clk_en_o;
    logic [NUM_CH-1:0]            ready_o;
    logic                         all_ready_o;

    modport master (
        output clk_i, arst_ni, clk_en_i, delay_i,
        input  clk_o, arst_no, clk_en_o, ready_o, all_ready_o
    );

    modport slave (
        input  clk_i, arst_ni, clk_en_i, delay_i,
        output clk_o, arst_no, clk_en_o, ready_o, all_ready_o
    );

endinterface

// File: rtl/soc_ctrl_clk_rst_seq_ch.sv
// One sequencer channel: reset synchroniser, IDLE/WAIT/RUN release FSM, delay counter and gating.
module soc_ctrl_clk_rst_seq_ch
    import soc_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             ref_clk_i,
    input  logic             glb_arst_ni,
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             clk_en_i,
    input  logic [CNT_W-1:0] delay_i,
    input  logic             prereq_i,
    output logic             clk_o,
    output logic             arst_no,
    output logic             clk_en_o,
    output logic             run_o
);

    logic [1:0]          sync_q;
    logic                rst_sync;
    soc_ctrl_seq_state_e state_q;
    soc_ctrl_seq_state_e state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    dly_q;
    logic [CNT_W-1:0]    dly_last;

    // Plain synchronous 2-flop chain: both assertion and de-assertion of the
    // domain reset take two ref_clk_i edges to reach the FSM.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ref_clk_i or negedge glb_arst_ni) begin
        if (!glb_arst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], arst_ni};
        end
    end

    assign rst_sync = sync_q[1];
    assign dly_last = dly_q - CNT_W'(1);

    always_ff @(posedge ref_clk_i or negedge glb_arst_ni) begin
        if (!glb_arst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset loss wins over a same-cycle WAIT->RUN condition.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (rst_sync && prereq_i) begin
                    state_d = (delay_i == '0) ? RUN : WAIT;
                end
            end
            WAIT: begin
                if (!rst_sync || !prereq_i) begin
                    state_d = IDLE;
                end else if (cnt_q == dly_last) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!rst_sync || !prereq_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The delay is captured only on leaving IDLE; later delay_i changes wait for the next release.
    always_ff @(posedge ref_clk_i or negedge glb_arst_ni) begin
        if (!glb_arst_ni) begin
            cnt_q <= '0;
            dly_q <= '0;
        end else begin
            cnt_q <= (state_q == WAIT && state_d == WAIT) ? cnt_q + CNT_W'(1) : '0;
            if (state_q == IDLE && state_d != IDLE) begin
                dly_q <= delay_i;
            end
        end
    end

    always_comb begin
        run_o    = (state_q == RUN);
        clk_en_o = clk_en_i & run_o;
        clk_o    = clk_i & clk_en_o;
        arst_no  = arst_ni;
    end

endmodule

// File: rtl/soc_ctrl_clk_rst_seq_gen.sv
// Multi-channel clock/reset release sequencer; channels optionally chained so each waits for its predecessor.
module soc_ctrl_clk_rst_seq_gen #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 8,
    parameter int SEQUENTIAL = 1
) (
    input logic                       ref_clk_i,
    input logic                       glb_arst_ni,
    soc_ctrl_clk_rst_seq_gen_if.slave bus
);

    logic [NUM_CH-1:0] run;
    logic [NUM_CH-1:0] prereq;
    logic [NUM_CH-1:0] ch_clk;
    logic [NUM_CH-1:0] ch_arst_n;
    logic [NUM_CH-1:0] ch_clk_en;
    logic              all_ready_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        if (SEQUENTIAL != 0 && i > 0) begin : g_chain
            assign prereq[i] = run[i-1];
        end else begin : g_free
            assign prereq[i] = 1'b1;
        end

        soc_ctrl_clk_rst_seq_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .ref_clk_i   (ref_clk_i),
            .glb_arst_ni (glb_arst_ni),
            .clk_i       (bus.clk_i[i]),
            .arst_ni     (bus.arst_ni[i]),
            .clk_en_i    (bus.clk_en_i[i]),
            .delay_i     (bus.delay_i[i]),
            .prereq_i    (prereq[i]),
            .clk_o       (ch_clk[i]),
            .arst_no     (ch_arst_n[i]),
            .clk_en_o    (ch_clk_en[i]),
            .run_o       (run[i])
        );
    end

    always_ff @(posedge ref_clk_i or negedge glb_arst_ni) begin
        if (!glb_arst_ni) begin
            all_ready_q <= 1'b0;
        end else begin
            all_ready_q <= &run;
        end
    end

    assign bus.clk_o       = ch_clk;
    assign bus.arst_no     = ch_arst_n;
    assign bus.clk_en_o    = ch_clk_en;
    assign bus.ready_o     = run;
    assign bus.all_ready_o = all_ready_q;

endmodule

// File: tb/tb_soc_ctrl_clk_rst_seq_gen.sv
// Bench for the clock/reset release sequencer: one independent and one chained instance, event scoreboard.
module tb_soc_ctrl_clk_rst_seq_gen;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    typedef logic [NUM_CH-1:0][CNT_W-1:0] dly_t;

    // ch == NUM_CH denotes all_ready_o
    typedef struct {
        int dut;
        int ch;
        int rise;
        int edge_n;
    } ev_t;

    typedef struct {
        int                dut;
        logic [NUM_CH-1:0] mask;
        dly_t              dly;
        int                off [NUM_CH+1];
        int                window;
    } rel_t;

    typedef struct {
        logic [NUM_CH-1:0] clk;
        logic [NUM_CH-1:0] en;
        logic [NUM_CH-1:0] exp_en;
        logic [NUM_CH-1:0] exp_clk;
    } gate_t;

    logic ref_clk    = 1'b0;
    logic glb_arst_n = 1'b0;
    int   ecnt       = 0;
    int   n_checks   = 0;
    int   n_errors   = 0;
    bit   mon_en     = 1'b0;
    ev_t  sb_q [$];
    logic [NUM_CH:0] prev [2];

    soc_ctrl_clk_rst_seq_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus_par ();
    soc_ctrl_clk_rst_seq_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus_seq ();

    soc_ctrl_clk_rst_seq_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SEQUENTIAL(0)) dut_par (
        .ref_clk_i   (ref_clk),
        .glb_arst_ni (glb_arst_n),
        .bus         (bus_par)
    );

    soc_ctrl_clk_rst_seq_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SEQUENTIAL(1)) dut_seq (
        .ref_clk_i   (ref_clk),
        .glb_arst_ni (glb_arst_n),
        .bus         (bus_seq)
    );

    always #5 ref_clk = ~ref_clk;

    always @(posedge ref_clk) ecnt <= ecnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int ev_key(input ev_t e);
        return e.edge_n * 100 + e.dut * 20 + e.ch * 2 + e.rise;
    endfunction

    task automatic push_ev(input int d, input int c, input int r, input int en);
        ev_t e;
        int  pos;
        e   = '{d, c, r, en};
        pos = sb_q.size();
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (ev_key(sb_q[i]) > ev_key(e)) pos = i;
        end
        sb_q.insert(pos, e);
    endtask

    task automatic sb_pop(input int d, input int c, input int r);
        ev_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL sb_unexpected: dut%0d ch%0d rise=%0d at edge %0d, no event expected",
                     d, c, r, ecnt);
            return;
        end
        e = sb_q.pop_front();
        if (e.dut != d || e.ch != c || e.rise != r || e.edge_n != ecnt) begin
            n_errors++;
            $display("FAIL sb_event: got dut%0d ch%0d rise=%0d edge %0d expected dut%0d ch%0d rise=%0d edge %0d",
                     d, c, r, ecnt, e.dut, e.ch, e.rise, e.edge_n);
        end
    endtask

    // Monitor: every ready/all_ready transition must match the head of the scoreboard.
    always @(negedge ref_clk) begin
        logic [NUM_CH:0] cur [2];
        cur[0] = {bus_par.all_ready_o, bus_par.ready_o};
        cur[1] = {bus_seq.all_ready_o, bus_seq.ready_o};
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c <= NUM_CH; c++) begin
                if (mon_en && cur[d][c] !== prev[d][c]) sb_pop(d, c, int'(cur[d][c]));
                prev[d][c] = cur[d][c];
            end
        end
    end

    task automatic set_arst(input int d, input logic [NUM_CH-1:0] v);
        if (d == 0) bus_par.arst_ni = v;
        else        bus_seq.arst_ni = v;
    endtask

    task automatic set_dly(input int d, input dly_t v);
        if (d == 0) bus_par.delay_i = v;
        else        bus_seq.delay_i = v;
    endtask

    task automatic start_release(input int d, input logic [NUM_CH-1:0] mask, input dly_t dly,
                                 input int off [NUM_CH+1], output int e0);
        @(negedge ref_clk);
        set_dly(d, dly);
        e0 = ecnt + 1;
        for (int c = 0; c <= NUM_CH; c++) begin
            if (off[c] >= 0) push_ev(d, c, 1, e0 + off[c]);
        end
        set_arst(d, mask);
    endtask

    task automatic wait_drain(input int n, input string name);
        repeat (n) @(negedge ref_clk);
        check({name, "_drain"}, 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    task automatic teardown();
        @(negedge ref_clk);
        mon_en = 1'b0;
        set_arst(0, '0);
        set_arst(1, '0);
        repeat (NUM_CH + 6) @(negedge ref_clk);
        sb_q.delete();
        mon_en = 1'b1;
    endtask

    initial begin
        rel_t  rel_tbl [4];
        gate_t gate_tbl [5];
        int    off [NUM_CH+1];
        int    e0;
        int    c0;

        rel_tbl[0] = '{0, 4'b1111, {8'd255, 8'd0, 8'd10, 8'd50}, '{52, 12, 2, 257, 258}, 262};
        rel_tbl[1] = '{1, 4'b1111, {8'd5, 8'd5, 8'd5, 8'd5},     '{7, 13, 19, 25, 26},   30};
        rel_tbl[2] = '{0, 4'b1111, {8'd4, 8'd3, 8'd2, 8'd1},     '{3, 4, 5, 6, 7},       11};
        rel_tbl[3] = '{1, 4'b1111, {8'd1, 8'd3, 8'd0, 8'd0},     '{2, 3, 7, 9, 10},      14};

        // applied with ready_o = 4'b0101 on the independent instance
        gate_tbl[0] = '{4'b1111, 4'b1111, 4'b0101, 4'b0101};
        gate_tbl[1] = '{4'b0000, 4'b1111, 4'b0101, 4'b0000};
        gate_tbl[2] = '{4'b1111, 4'b0011, 4'b0001, 4'b0001};
        gate_tbl[3] = '{4'b1010, 4'b1110, 4'b0100, 4'b0000};
        gate_tbl[4] = '{4'b0110, 4'b0111, 4'b0101, 4'b0100};

        bus_par.clk_i = '1;  bus_par.clk_en_i = '1;  bus_par.arst_ni = 4'b1010;  bus_par.delay_i = '0;
        bus_seq.clk_i = '1;  bus_seq.clk_en_i = '1;  bus_seq.arst_ni = 4'b0101;  bus_seq.delay_i = '0;

        // Global reset state
        repeat (3) @(negedge ref_clk);
        check("rst_ready",     bus_par.ready_o,     4'b0000);
        check("rst_all_ready", bus_par.all_ready_o, 1'b0);
        check("rst_clk_en_o",  bus_par.clk_en_o,    4'b0000);
        check("rst_clk_o",     bus_par.clk_o,       4'b0000);
        check("rst_arst_no",   bus_par.arst_no,     4'b1010);
        check("rst_seq_ready", bus_seq.ready_o,     4'b0000);
        check("rst_seq_arst_no", bus_seq.arst_no,   4'b0101);

        @(negedge ref_clk);
        set_arst(0, '0);
        set_arst(1, '0);
        glb_arst_n = 1'b1;
        mon_en     = 1'b1;

        // Release timing table
        for (int i = 0; i < 4; i++) begin
            teardown();
            start_release(rel_tbl[i].dut, rel_tbl[i].mask, rel_tbl[i].dly, rel_tbl[i].off, e0);
            wait_drain(rel_tbl[i].window, $sformatf("release%0d", i));
        end

        // Chained teardown: channel 0 reset drop cascades one edge per channel
        teardown();
        start_release(1, rel_tbl[1].mask, rel_tbl[1].dly, rel_tbl[1].off, e0);
        wait_drain(rel_tbl[1].window, "seq_setup");
        @(negedge ref_clk);
        c0 = ecnt;
        bus_seq.arst_ni[0] = 1'b0;
        push_ev(1, 0,      0, c0 + 3);
        push_ev(1, 1,      0, c0 + 4);
        push_ev(1, NUM_CH, 0, c0 + 4);
        push_ev(1, 2,      0, c0 + 5);
        push_ev(1, 3,      0, c0 + 6);
        #1;
        check("seq_arst_no_comb",     bus_seq.arst_no, 4'b1110);
        check("seq_ready_before_gate", bus_seq.ready_o, 4'b1111);
        wait_drain(9, "seq_cascade");
        check("seq_clk_o_gated",    bus_seq.clk_o,    4'b0000);
        check("seq_clk_en_o_gated", bus_seq.clk_en_o, 4'b0000);

        // Channel 1 reset dropped mid-WAIT at cnt=3, then re-released
        teardown();
        off = '{-1, -1, -1, -1, -1};
        start_release(0, 4'b0010, {8'd0, 8'd0, 8'd10, 8'd0}, off, e0);
        repeat (6) @(negedge ref_clk);
        bus_par.arst_ni[1] = 1'b0;
        repeat (14) @(negedge ref_clk);
        check("midwait_no_release", bus_par.ready_o, 4'b0000);
        off = '{-1, 12, -1, -1, -1};
        start_release(0, 4'b0010, {8'd0, 8'd0, 8'd10, 8'd0}, off, e0);
        wait_drain(16, "midwait_restart");

        // delay_i change during WAIT is ignored
        teardown();
        off = '{22, -1, -1, -1, -1};
        start_release(0, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd20}, off, e0);
        repeat (6) @(negedge ref_clk);
        bus_par.delay_i[0] = 8'd2;
        wait_drain(22, "dly_change");

        // Gating vectors with channels 0 and 2 in RUN
        teardown();
        off = '{2, -1, 2, -1, -1};
        start_release(0, 4'b0101, '0, off, e0);
        wait_drain(5, "gate_setup");
        for (int i = 0; i < 5; i++) begin
            @(negedge ref_clk);
            bus_par.clk_i    = gate_tbl[i].clk;
            bus_par.clk_en_i = gate_tbl[i].en;
            #1;
            check($sformatf("gate%0d_clk_en_o", i), bus_par.clk_en_o, gate_tbl[i].exp_en);
            check($sformatf("gate%0d_clk_o", i),    bus_par.clk_o,    gate_tbl[i].exp_clk);
            check($sformatf("gate%0d_arst_no", i),  bus_par.arst_no,  4'b0101);
        end

        // Global reset mid-RUN clears asynchronously, then a clean re-release
        teardown();
        off = '{2, 2, 2, 2, 3};
        start_release(0, 4'b1111, '0, off, e0);
        wait_drain(6, "glb_setup");
        bus_par.clk_i    = '1;
        bus_par.clk_en_i = '1;
        @(posedge ref_clk);
        #2;
        mon_en     = 1'b0;
        glb_arst_n = 1'b0;
        #1;
        check("glb_ready",     bus_par.ready_o,     4'b0000);
        check("glb_all_ready", bus_par.all_ready_o, 1'b0);
        check("glb_clk_en_o",  bus_par.clk_en_o,    4'b0000);
        check("glb_clk_o",     bus_par.clk_o,       4'b0000);
        check("glb_arst_no",   bus_par.arst_no,     4'b1111);
        @(negedge ref_clk);
        @(negedge ref_clk);
        bus_par.delay_i = {8'd2, 8'd1, 8'd0, 8'd3};
        e0 = ecnt + 1;
        push_ev(0, 0,      1, e0 + 5);
        push_ev(0, 1,      1, e0 + 2);
        push_ev(0, 2,      1, e0 + 3);
        push_ev(0, 3,      1, e0 + 4);
        push_ev(0, NUM_CH, 1, e0 + 6);
        glb_arst_n = 1'b1;
        mon_en     = 1'b1;
        wait_drain(10, "glb_rerelease");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
